battle_attack_seq: RTL and testbench

- Sequences one attack resolution in the battle engine.
- Time-multiplexes the single shared pokemon-ID-to-type lookup (5-bit ID in, 3-bit type out, combinational) for attacker then defender, and computes type-scaled damage.
- Drains defender HP one point per DRAIN_DIV clocks so the HP bar animates; sits between the battle menu FSM and the HP/sprite display logic.

---
 rtl/battle_attack_seq_pkg.sv | 63 ++++++
 rtl/battle_attack_seq_if.sv | 36 +++
 rtl/battle_attack_seq_hp_drain_ctr.sv | 67 ++++++
 rtl/battle_attack_seq.sv | 136 +++++++++++++
 tb/tb_battle_attack_seq.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/battle_attack_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : battle_pkg                                                 |
// | Brief   : Shared battle types and the type-effectiveness function.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package battle_pkg;

    typedef enum logic [2:0] {
        T_GRASS    = 3'b000,
        T_FIRE     = 3'b001,
        T_WATER    = 3'b010,
        T_ELECTRIC = 3'b011,
        T_FLYING   = 3'b100,
        T_ROCK     = 3'b101,
        T_NORMAL   = 3'b110,
        T_NONE     = 3'b111
    } type_t;

    typedef enum logic [1:0] {
        EFF_NEUTRAL  = 2'b00,
        EFF_SUPER    = 2'b01,
        EFF_NOT_VERY = 2'b10
    } eff_t;

    // True when attacker type a is strong against defender type d.
    function automatic logic is_super(input type_t a, input type_t d);
        logic r;
        r = 1'b0;
        case ({a, d})
            {T_FIRE,     T_GRASS },
            {T_WATER,    T_FIRE  },
            {T_GRASS,    T_WATER },
            {T_ELECTRIC, T_WATER },
            {T_ELECTRIC, T_FLYING},
            {T_ROCK,     T_FIRE  },
            {T_ROCK,     T_FLYING},
            {T_GRASS,    T_ROCK  },
            {T_WATER,    T_ROCK  },
            {T_FLYING,   T_GRASS }: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Not-very covers reversed super pairs and same-type grass/fire/water;
    // normal and none never appear in the table so they fall to neutral.
    function automatic eff_t effectiveness(input type_t atk_t, input type_t def_t);
        eff_t e;
        if (is_super(atk_t, def_t)) begin
            e = EFF_SUPER;
        end else if (is_super(def_t, atk_t) ||
                     ((atk_t == def_t) &&
                      ((atk_t == T_GRASS) || (atk_t == T_FIRE) || (atk_t == T_WATER)))) begin
            e = EFF_NOT_VERY;
        end else begin
            e = EFF_NEUTRAL;
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/battle_attack_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : battle_attack_seq_if                                       |
// | Brief   : Menu/lookup/display bundle for the attack sequencer.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface battle_attack_seq_if #(
    parameter int HP_W = 8
);
    logic            req;
    logic [4:0]      atk_id;
    logic [4:0]      def_id;
    logic [HP_W-1:0] base_power;
    logic [HP_W-1:0] def_hp_in;
    logic [4:0]      lookup_id;
    logic [2:0]      lookup_type;
    logic            busy;
    logic [1:0]      eff;
    logic [HP_W-1:0] damage;
    logic [HP_W-1:0] hp_out;
    logic            done;
    logic            fainted;

    // System side: menu request, shared type lookup and display sink.
    modport master (
        output req, atk_id, def_id, base_power, def_hp_in, lookup_type,
        input  lookup_id, busy, eff, damage, hp_out, done, fainted
    );

    // Sequencer side.
    modport slave (
        input  req, atk_id, def_id, base_power, def_hp_in, lookup_type,
        output lookup_id, busy, eff, damage, hp_out, done, fainted
    );
endinterface
`default_nettype wire

// File: rtl/battle_attack_seq_hp_drain_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hp_drain_ctr                                               |
// | Brief   : Clock divider plus remaining-damage and HP down-counters   |
// |           that stop at zero.                                         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module hp_drain_ctr #(
    parameter int DRAIN_DIV = 4,
    parameter int HP_W      = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_hp_load,
    input  wire logic [HP_W-1:0] i_hp_init,
    input  wire logic            i_rem_load,
    input  wire logic [HP_W-1:0] i_rem_init,
    input  wire logic            i_en,
    output logic      [HP_W-1:0] o_hp,
    output logic                 o_fin
);
    localparam int                 c_DIV_W    = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DRAIN_DIV - 1);

    logic [HP_W-1:0]    r_hp;
    logic [HP_W-1:0]    r_rem;
    logic [c_DIV_W-1:0] r_div;
    logic               w_zero;
    logic               w_tick;
    logic               w_last_step;

    // Decrement on divider wrap; fin is raised in the cycle that empties
    // either counter (or immediately if one is already empty).
    always_comb begin
        w_zero      = (r_rem == '0) || (r_hp == '0);
        w_tick      = i_en && !w_zero && (r_div == c_DIV_LAST);
        w_last_step = w_tick && ((r_rem == HP_W'(1)) || (r_hp == HP_W'(1)));
        o_fin       = i_en && (w_zero || w_last_step);
        o_hp        = r_hp;
    end

    // Counter state; the divider restarts whenever a new damage value loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hp  <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else begin
            if (i_hp_load) begin
                r_hp <= i_hp_init;
            end else if (w_tick) begin
                r_hp <= r_hp - HP_W'(1);
            end

            if (i_rem_load) begin
                r_rem <= i_rem_init;
                r_div <= '0;
            end else if (w_tick) begin
                r_rem <= r_rem - HP_W'(1);
                r_div <= '0;
            end else if (i_en) begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/battle_attack_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : battle_attack_seq                                          |
// | Brief   : Looks up attacker/defender types, scales damage and        |
// |           drains defender HP for display animation.                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module battle_attack_seq
    import battle_pkg::*;
#(
    parameter int DRAIN_DIV = 4,
    parameter int HP_W      = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    battle_attack_seq_if.slave bus
);
    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_LOOK_ATK = 3'd1;
    localparam logic [2:0] c_S_LOOK_DEF = 3'd2;
    localparam logic [2:0] c_S_CALC     = 3'd3;
    localparam logic [2:0] c_S_DRAIN    = 3'd4;
    localparam logic [2:0] c_S_DONE     = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [4:0]      r_atk_id;
    logic [4:0]      r_def_id;
    logic [HP_W-1:0] r_power;
    type_t           r_atk_t;
    type_t           r_def_t;
    eff_t            r_eff;
    logic [HP_W-1:0] r_damage;

    logic            w_accept;
    eff_t            w_eff;
    logic [HP_W:0]   w_dbl;
    logic [HP_W-1:0] w_half;
    logic [HP_W-1:0] w_dmg;
    logic [HP_W-1:0] w_hp;
    logic            w_fin;

    assign w_accept = (r_state == c_S_IDLE) && bus.req;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; req outside IDLE (including DONE) is dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:     if (bus.req) w_next = c_S_LOOK_ATK;
            c_S_LOOK_ATK: w_next = c_S_LOOK_DEF;
            c_S_LOOK_DEF: w_next = c_S_CALC;
            c_S_CALC:     w_next = c_S_DRAIN;
            c_S_DRAIN:    if (w_fin) w_next = c_S_DONE;
            c_S_DONE:     w_next = c_S_IDLE;
            default:      w_next = c_S_IDLE;
        endcase
    end

    // State-decoded outputs, including the shared lookup address.
    always_comb begin
        bus.busy      = (r_state == c_S_LOOK_ATK) || (r_state == c_S_LOOK_DEF) ||
                        (r_state == c_S_CALC)     || (r_state == c_S_DRAIN);
        bus.done      = (r_state == c_S_DONE);
        bus.fainted   = (r_state == c_S_DONE) && (w_hp == '0);
        bus.lookup_id = 5'd0;
        if (r_state == c_S_LOOK_ATK) bus.lookup_id = r_atk_id;
        if (r_state == c_S_LOOK_DEF) bus.lookup_id = r_def_id;
    end

    // Damage scaling: super doubles with saturation, not-very halves but
    // never rounds a non-zero power down to zero.
    always_comb begin
        w_eff  = effectiveness(r_atk_t, r_def_t);
        w_dbl  = {1'b0, r_power} << 1;
        w_half = r_power >> 1;
        case (w_eff)
            EFF_SUPER:    w_dmg = w_dbl[HP_W] ? '1 : w_dbl[HP_W-1:0];
            EFF_NOT_VERY: w_dmg = ((r_power != '0) && (w_half == '0)) ? HP_W'(1) : w_half;
            default:      w_dmg = r_power;
        endcase
    end

    // Request capture, type registration and result hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_atk_id <= '0;
            r_def_id <= '0;
            r_power  <= '0;
            r_atk_t  <= T_GRASS;
            r_def_t  <= T_GRASS;
            r_eff    <= EFF_NEUTRAL;
            r_damage <= '0;
        end else begin
            if (w_accept) begin
                r_atk_id <= bus.atk_id;
                r_def_id <= bus.def_id;
                r_power  <= bus.base_power;
            end
            if (r_state == c_S_LOOK_ATK) r_atk_t <= type_t'(bus.lookup_type);
            if (r_state == c_S_LOOK_DEF) r_def_t <= type_t'(bus.lookup_type);
            if (r_state == c_S_CALC) begin
                r_eff    <= w_eff;
                r_damage <= w_dmg;
            end
        end
    end

    hp_drain_ctr #(
        .DRAIN_DIV (DRAIN_DIV),
        .HP_W      (HP_W)
    ) u_drain (
        .clk        (clk),
        .rst        (reset),
        .i_hp_load  (w_accept),
        .i_hp_init  (bus.def_hp_in),
        .i_rem_load (r_state == c_S_CALC),
        .i_rem_init (w_dmg),
        .i_en       (r_state == c_S_DRAIN),
        .o_hp       (w_hp),
        .o_fin      (w_fin)
    );

    assign bus.eff    = r_eff;
    assign bus.damage = r_damage;
    assign bus.hp_out = w_hp;
endmodule
`default_nettype wire

// File: tb/tb_battle_attack_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_battle_attack_seq                                       |
// | Brief   : Scoreboard bench for the attack sequencer.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_battle_attack_seq;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    battle_attack_seq_if #(.HP_W(8)) bif();

    battle_attack_seq #(
        .DRAIN_DIV (DIV),
        .HP_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] eff;
        logic [7:0] dmg;
        logic [7:0] hp;
        logic       faint;
        int         lat;
    } exp_t;
    exp_t sb[$];

    // Attacker/defender pairs (octal: attacker digit, defender digit).
    logic [5:0] super_pairs [10] = '{6'o10, 6'o21, 6'o02, 6'o32, 6'o34,
                                     6'o51, 6'o54, 6'o05, 6'o25, 6'o40};

    // Model of the external ID-to-type ROM.
    function automatic logic [2:0] tb_type(input logic [4:0] id);
        logic [2:0] t;
        case (id)
            5'd0:    t = 3'b111;
            5'd4:    t = 3'b001;
            5'd5:    t = 3'b010;
            5'd6:    t = 3'b000;
            5'd7:    t = 3'b001;
            5'd8:    t = 3'b010;
            5'd9:    t = 3'b101;
            5'd12:   t = 3'b011;
            5'd20:   t = 3'b100;
            default: t = 3'b110;
        endcase
        return t;
    endfunction

    always_comb bif.lookup_type = tb_type(bif.lookup_id);

    function automatic logic [1:0] tb_eff(input logic [2:0] a, input logic [2:0] d);
        for (int i = 0; i < 10; i++) if (super_pairs[i] == {a, d}) return 2'b01;
        for (int i = 0; i < 10; i++) if (super_pairs[i] == {d, a}) return 2'b10;
        if ((a == d) && (a <= 3'd2)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int tb_dmg(input logic [1:0] e, input int p);
        int v;
        if (e == 2'b01) begin
            v = 2 * p;
            if (v > 255) v = 255;
        end else if (e == 2'b10) begin
            v = (p == 0) ? 0 : ((p / 2 < 1) ? 1 : p / 2);
        end else begin
            v = p;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full attack: push expectation at request, pop and compare at done.
    task automatic run_attack(input string name, input logic [4:0] atk, input logic [4:0] def,
                              input int pow, input int hp, input int glitch);
        exp_t e;
        exp_t g;
        int   c;
        int   applied;
        int   exp_hp;
        logic hp_ok;
        logic got_done;
        e.eff   = tb_eff(tb_type(atk), tb_type(def));
        e.dmg   = 8'(tb_dmg(e.eff, pow));
        applied = (int'(e.dmg) < hp) ? int'(e.dmg) : hp;
        e.hp    = 8'(hp - applied);
        e.faint = (e.hp == 8'd0);
        e.lat   = (applied == 0) ? 5 : 4 + applied * DIV;
        sb.push_back(e);

        bif.req = 1'b1; bif.atk_id = atk; bif.def_id = def;
        bif.base_power = 8'(pow); bif.def_hp_in = 8'(hp);
        tick();
        bif.req = 1'b0; bif.atk_id = ~atk; bif.def_id = ~def;
        c = 1;
        n_tests++;
        if (bif.busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_rise: got %b want 1", name, bif.busy);
        end
        n_tests++;
        if (bif.lookup_id !== atk) begin
            n_fail++; $display("FAIL %s lookup_atk: got %b want %b", name, bif.lookup_id, atk);
        end
        tick(); c = 2;
        n_tests++;
        if (bif.lookup_id !== def) begin
            n_fail++; $display("FAIL %s lookup_def: got %b want %b", name, bif.lookup_id, def);
        end

        hp_ok = 1'b1; got_done = 1'b0;
        while (c < e.lat + 20) begin
            tick(); c++;
            bif.req = (c == glitch);
            if (c == glitch) begin
                bif.atk_id = 5'd12; bif.def_id = 5'd20;
                bif.base_power = 8'd200; bif.def_hp_in = 8'd99;
            end
            if (bif.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (c >= 4) begin
                exp_hp = hp - (((c - 4) / DIV < applied) ? (c - 4) / DIV : applied);
                if (bif.hp_out !== 8'(exp_hp)) hp_ok = 1'b0;
            end
        end
        bif.req = 1'b0;

        n_tests++;
        if (!hp_ok) begin
            n_fail++; $display("FAIL %s hp_trace: hp_out got off the expected staircase (last %0d)", name, bif.hp_out);
        end
        n_tests++;
        if (!got_done || c != e.lat) begin
            n_fail++; $display("FAIL %s latency: got %0d (done seen %b) want %0d", name, c, got_done, e.lat);
        end
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
        end else begin
            g = sb.pop_front();
            n_tests++;
            if (bif.eff !== g.eff) begin
                n_fail++; $display("FAIL %s eff: got %b want %b", name, bif.eff, g.eff);
            end
            n_tests++;
            if (bif.damage !== g.dmg) begin
                n_fail++; $display("FAIL %s damage: got %0d want %0d", name, bif.damage, g.dmg);
            end
            n_tests++;
            if (bif.hp_out !== g.hp) begin
                n_fail++; $display("FAIL %s hp_final: got %0d want %0d", name, bif.hp_out, g.hp);
            end
            n_tests++;
            if (bif.fainted !== g.faint) begin
                n_fail++; $display("FAIL %s fainted: got %b want %b", name, bif.fainted, g.faint);
            end
            n_tests++;
            if (bif.busy !== 1'b0) begin
                n_fail++; $display("FAIL %s busy_at_done: got %b want 0", name, bif.busy);
            end
            tick();
            n_tests++;
            if (bif.done !== 1'b0 || bif.hp_out !== g.hp) begin
                n_fail++; $display("FAIL %s after_done: done %b hp %0d want done 0 hp %0d",
                                   name, bif.done, bif.hp_out, g.hp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bif.req = 1'b0; bif.atk_id = '0; bif.def_id = '0;
        bif.base_power = '0; bif.def_hp_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if ({bif.busy, bif.done, bif.fainted} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: busy/done/fainted got %b want 000",
                               {bif.busy, bif.done, bif.fainted});
        end
        n_tests++;
        if (bif.eff !== 2'b00 || bif.damage !== 8'd0) begin
            n_fail++; $display("FAIL reset_result: eff %b damage %0d want 00/0", bif.eff, bif.damage);
        end
        n_tests++;
        if (bif.hp_out !== 8'd0 || bif.lookup_id !== 5'd0) begin
            n_fail++; $display("FAIL reset_hp_lookup: hp %0d lookup %0d want 0/0", bif.hp_out, bif.lookup_id);
        end
    endtask

    task automatic test_super();
        run_attack("fire_grass", 5'd4, 5'd6, 20, 50, 10);
    endtask

    task automatic test_faint();
        run_attack("water_fire_faint", 5'd5, 5'd7, 100, 30, -1);
    endtask

    task automatic test_not_very();
        run_attack("water_water_p1", 5'd5, 5'd8, 1, 10, -1);
        run_attack("water_water_p9", 5'd5, 5'd8, 9, 10, -1);
    endtask

    task automatic test_neutral();
        run_attack("fire_none", 5'd4, 5'd0, 15, 15, -1);
    endtask

    task automatic test_saturation();
        run_attack("elec_flying_sat", 5'd12, 5'd20, 200, 5, -1);
    endtask

    task automatic test_zero();
        run_attack("zero_power", 5'd9, 5'd4, 0, 40, -1);
        run_attack("zero_hp", 5'd4, 5'd6, 20, 0, -1);
    endtask

    // req held high through DONE: second accept lands the cycle after done.
    task automatic test_back_to_back();
        int c;
        int c_done;
        bif.req = 1'b1; bif.atk_id = 5'd4; bif.def_id = 5'd0;
        bif.base_power = 8'd0; bif.def_hp_in = 8'd7;
        c = 0; c_done = -1;
        while (c < 30 && c_done < 0) begin
            tick(); c++;
            if (bif.done === 1'b1) c_done = c;
        end
        n_tests++;
        if (c_done != 5) begin
            n_fail++; $display("FAIL b2b_first_done: got cycle %0d want 5", c_done);
        end
        bif.base_power = 8'd3;
        tick(); c++;
        n_tests++;
        if (bif.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done_req_ignored: busy got %b want 0", bif.busy);
        end
        tick(); c++;
        bif.req = 1'b0;
        n_tests++;
        if (bif.busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_accept: busy got %b want 1", bif.busy);
        end
        c_done = -1;
        while (c < 60 && c_done < 0) begin
            tick(); c++;
            if (bif.done === 1'b1) c_done = c;
        end
        n_tests++;
        if (c_done != 22 || bif.damage !== 8'd3) begin
            n_fail++; $display("FAIL b2b_second_done: cycle %0d damage %0d want 22/3", c_done, bif.damage);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        logic saw_done;
        bif.req = 1'b1; bif.atk_id = 5'd4; bif.def_id = 5'd6;
        bif.base_power = 8'd20; bif.def_hp_in = 8'd50;
        tick();
        bif.req = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (bif.busy !== 1'b0 || bif.hp_out !== 8'd0 || bif.done !== 1'b0 || bif.damage !== 8'd0) begin
            n_fail++; $display("FAIL midreset_state: busy %b hp %0d done %b dmg %0d want 0/0/0/0",
                               bif.busy, bif.hp_out, bif.done, bif.damage);
        end
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bif.done === 1'b1 || bif.busy === 1'b1) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++; $display("FAIL midreset_no_done: activity got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_super();
        test_faint();
        test_not_very();
        test_neutral();
        test_saturation();
        test_zero();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
